// File: rtl/usbh_data_tx.sv
// usbh_data_tx: drains the host TX FIFO into one USB DATA packet on the UTMI transmit port.
// Build option USBH_DATA_TX_CRC_EN: append CRC16 here; otherwise the SIE appends it.
module usbh_data_tx #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [7:0]       pid_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             underrun_o,
    input  logic [7:0]       fifo_data_i,
    input  logic             fifo_empty_i,
    output logic             fifo_pop_o,
    output logic [7:0]       utmi_data_o,
    output logic             utmi_txvalid_o,
    input  logic             utmi_txready_i
);

    // state    | meaning
    // S_IDLE   | waiting for start_i
    // S_PID    | sending captured PID byte
    // S_DATA   | streaming payload straight from the FIFO head
    // S_CRC_LO | sending inverted CRC low byte  (CRC build only)
    // S_CRC_HI | sending inverted CRC high byte (CRC build only)
    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA
`ifdef USBH_DATA_TX_CRC_EN
        , S_CRC_LO
        , S_CRC_HI
`endif
    } state_t;

    state_t           state;
    logic [7:0]       pid_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic             tx_accept;

`ifdef USBH_DATA_TX_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction
`endif

    assign cnt_nxt   = cnt + LEN_W'(1);
    assign tx_accept = utmi_txvalid_o && utmi_txready_i;
    assign busy_o    = (state != S_IDLE);

    // Payload path is combinational so the FWFT head moves without a bubble.
    always_comb begin
        utmi_txvalid_o = 1'b0;
        utmi_data_o    = 8'h00;
        fifo_pop_o     = 1'b0;
        case (state)
            S_PID: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = pid_q;
            end
            S_DATA: begin
                utmi_txvalid_o = !fifo_empty_i;
                utmi_data_o    = fifo_data_i;
                fifo_pop_o     = utmi_txready_i && !fifo_empty_i;
            end
`ifdef USBH_DATA_TX_CRC_EN
            S_CRC_LO: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = ~crc[7:0];
            end
            S_CRC_HI: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = ~crc[15:8];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            pid_q      <= 8'h00;
            len_q      <= '0;
            cnt        <= '0;
            done_o     <= 1'b0;
            underrun_o <= 1'b0;
`ifdef USBH_DATA_TX_CRC_EN
            crc        <= 16'hFFFF;
`endif
        end else begin
            done_o     <= 1'b0;
            underrun_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        pid_q <= pid_i;
                        len_q <= (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
`ifdef USBH_DATA_TX_CRC_EN
                        crc   <= 16'hFFFF;
`endif
                        state <= S_PID;
                    end
                end
                S_PID: begin
                    if (tx_accept) begin
                        cnt <= '0;
                        if (len_q != '0) begin
                            state <= S_DATA;
                        end else begin
`ifdef USBH_DATA_TX_CRC_EN
                            state  <= S_CRC_LO;
`else
                            state  <= S_IDLE;
                            done_o <= 1'b1;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (fifo_empty_i) begin
                        state      <= S_IDLE;
                        underrun_o <= 1'b1;
                    end else if (utmi_txready_i) begin
`ifdef USBH_DATA_TX_CRC_EN
                        crc <= crc16_byte(crc, fifo_data_i);
`endif
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
`ifdef USBH_DATA_TX_CRC_EN
                            state  <= S_CRC_LO;
`else
                            state  <= S_IDLE;
                            done_o <= 1'b1;
`endif
                        end
                    end
                end
`ifdef USBH_DATA_TX_CRC_EN
                S_CRC_LO: begin
                    if (tx_accept) state <= S_CRC_HI;
                end
                S_CRC_HI: begin
                    if (tx_accept) begin
                        state  <= S_IDLE;
                        done_o <= 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usbh_data_tx.sv
// Bench for usbh_data_tx: table vectors plus random packets against a queue-based packet model.
`timescale 1ns/1ps
module tb_usbh_data_tx;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;
`ifdef USBH_DATA_TX_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [7:0]       pid;
    logic [LEN_W-1:0] len;
    logic             busy, done, underrun;
    logic [7:0]       fifo_data;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [7:0]       utmi_data;
    logic             txvalid;
    logic             txready;

    usbh_data_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pid_i(pid), .len_i(len),
        .busy_o(busy), .done_o(done), .underrun_o(underrun),
        .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_pop_o(fifo_pop),
        .utmi_data_o(utmi_data), .utmi_txvalid_o(txvalid), .utmi_txready_i(txready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pid;
        int         len;
        int         nfifo;
        int         rdy;       // 0 always ready, 1 toggling, 2 random
        bit         incr;
        bit         poke;
        int         exp_pay;
        bit         exp_done;
        bit         exp_und;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] tx_q[$];
    int first_valid, last_acc, done_cyc, und_cyc, pops, pop_bad, gap, done_n, und_n;
    int done_busy, und_busy, und_prev_valid, prev_valid;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        bit fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic clear_log();
        tx_q.delete();
        first_valid = -1; last_acc = -1; done_cyc = -1; und_cyc = -1;
        pops = 0; pop_bad = 0; gap = 0; done_n = 0; und_n = 0;
        done_busy = -1; und_busy = -1; und_prev_valid = -1; prev_valid = 0;
    endtask

    // One clock: observe at negedge, apply the FIFO pop just after posedge.
    task automatic tick();
        bit pend;
        @(negedge clk);
        pend = 1'b0;
        if (txvalid) begin
            if (first_valid < 0) first_valid = cyc;
        end else if (busy && first_valid >= 0 && !fifo_empty) begin
            gap++;
        end
        if (txvalid && txready) begin
            tx_q.push_back(utmi_data);
            last_acc = cyc;
        end
        if (fifo_pop) begin
            pops++;
            if (!(txvalid && txready)) pop_bad++;
            pend = 1'b1;
        end
        if (done) begin done_n++; done_cyc = cyc; done_busy = int'(busy); end
        if (underrun) begin und_n++; und_cyc = cyc; und_busy = int'(busy); und_prev_valid = prev_valid; end
        prev_valid = int'(txvalid);
        @(posedge clk);
        #1;
        if (pend && fifo_q.size() > 0) fifo_q.delete(0);
        fifo_refresh();
        cyc++;
    endtask

    task automatic set_ready(input int mode, input int i);
        case (mode)
            0:       txready = 1'b1;
            1:       txready = (i % 2 == 0);
            default: txready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_packet(input vec_t v, input string tag);
        int L, npay, start_cyc, budget, diff;
        logic [7:0] exp_q[$];
        logic [7:0] img[$];
        logic [15:0] c;
        clear_log();
        fifo_q.delete();
        for (int i = 0; i < v.nfifo; i++)
            fifo_q.push_back(v.incr ? 8'(i) : 8'($urandom_range(0, 255)));
        img = fifo_q;
        fifo_refresh();

        L    = (v.len > MAX_LEN) ? MAX_LEN : v.len;
        npay = (v.nfifo < L) ? v.nfifo : L;
        exp_q.push_back(v.pid);
        c = 16'hFFFF;
        for (int i = 0; i < npay; i++) begin
            exp_q.push_back(img[i]);
            c = crc_ref(c, img[i]);
        end
        if (CRC_EN && npay == L) begin
            exp_q.push_back(~c[7:0]);
            exp_q.push_back(~c[15:8]);
        end

        pid = v.pid; len = LEN_W'(v.len); start = 1'b1; start_cyc = cyc;
        set_ready(v.rdy, 0);
        tick();
        start = 1'b0; pid = 8'h00; len = '0;
        budget = 0;
        while ((done_n + und_n) == 0 && budget < 1000) begin
            if (v.poke && budget == 2) begin
                start = 1'b1; pid = 8'h5A; len = LEN_W'(3);
            end else begin
                start = 1'b0;
            end
            set_ready(v.rdy, budget + 1);
            tick();
            budget++;
        end
        start = 1'b0; txready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        txready = 1'b0;

        chk({tag, " timeout"}, int'(budget >= 1000), 0);
        chk({tag, " nbytes"}, tx_q.size(), exp_q.size());
        diff = -1;
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            if (diff < 0 && tx_q[i] != exp_q[i]) diff = i;
        chk({tag, " first_bad_byte_idx"}, diff, -1);
        chk({tag, " pops"}, pops, v.exp_pay);
        chk({tag, " done_cnt"}, done_n, int'(v.exp_done));
        chk({tag, " underrun_cnt"}, und_n, int'(v.exp_und));
        chk({tag, " pid_latency"}, first_valid - start_cyc, 1);
        chk({tag, " txvalid_gaps"}, gap, 0);
        chk({tag, " pop_without_accept"}, pop_bad, 0);
        chk({tag, " fifo_left"}, fifo_q.size(), v.nfifo - v.exp_pay);
        if (v.exp_done) begin
            chk({tag, " done_delay"}, done_cyc - last_acc, 1);
            chk({tag, " busy_at_done"}, done_busy, 0);
`ifdef USBH_DATA_TX_CRC_EN
            c = 16'hFFFF;
            for (int i = 1; i < tx_q.size(); i++) c = crc_ref(c, tx_q[i]);
            chk({tag, " crc_residual"}, int'(bitrev16(c)), 16'h800D);
`endif
        end
        if (v.exp_und) begin
            chk({tag, " underrun_delay"}, und_cyc - last_acc, 2);
            chk({tag, " busy_at_underrun"}, und_busy, 0);
            chk({tag, " txvalid_before_underrun"}, und_prev_valid, 0);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " underrun"}, int'(underrun), 0);
        chk({tag, " fifo_pop"}, int'(fifo_pop), 0);
        chk({tag, " txvalid"}, int'(txvalid), 0);
        chk({tag, " utmi_data"}, int'(utmi_data), 0);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t rv;
        int   L, budget;

        tbl[0] = '{8'h4B,   0,  0, 0, 1'b0, 1'b0,  0, 1'b1, 1'b0};
        tbl[1] = '{8'hC3,   4,  4, 0, 1'b1, 1'b0,  4, 1'b1, 1'b0};
        tbl[2] = '{8'hC3,   4,  4, 1, 1'b1, 1'b0,  4, 1'b1, 1'b0};
        tbl[3] = '{8'h4B,   8,  3, 0, 1'b0, 1'b0,  3, 1'b0, 1'b1};
        tbl[4] = '{8'hC3, 100, 70, 0, 1'b0, 1'b0, 64, 1'b1, 1'b0};
        tbl[5] = '{8'h4B,   5,  5, 0, 1'b1, 1'b1,  5, 1'b1, 1'b0};
        tbl[6] = '{8'hC3,  64, 64, 2, 1'b0, 1'b0, 64, 1'b1, 1'b0};
        tbl[7] = '{8'h4B,   1,  1, 1, 1'b0, 1'b0,  1, 1'b1, 1'b0};
        tbl[8] = '{8'hC3,   2,  0, 0, 1'b0, 1'b0,  0, 1'b0, 1'b1};
        tbl[9] = '{8'h4B,  64, 65, 1, 1'b0, 1'b1, 64, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; pid = 8'h00; len = '0; txready = 1'b0;
        fifo_q.delete();
        fifo_refresh();
        clear_log();
        tick();
        tick();
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 10; t++) run_packet(tbl[t], $sformatf("vec%0d", t));

        // Reset in the middle of the payload, then a clean packet.
        clear_log();
        fifo_q.delete();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h10 + i));
        fifo_refresh();
        pid = 8'hC3; len = LEN_W'(8); start = 1'b1; txready = 1'b1;
        tick();
        start = 1'b0;
        budget = 0;
        while (tx_q.size() < 3 && budget < 50) begin
            tick();
            budget++;
        end
        chk("midreset timeout", int'(budget >= 50), 0);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk_idle_outputs("midreset");
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        txready = 1'b0;
        tick();
        run_packet(tbl[1], "after_reset");

        for (int r = 0; r < 16; r++) begin
            rv.pid   = ($urandom_range(0, 1) != 0) ? 8'hC3 : 8'h4B;
            rv.len   = $urandom_range(0, 100);
            L        = (rv.len > MAX_LEN) ? MAX_LEN : rv.len;
            rv.nfifo = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L) : L + $urandom_range(0, 4);
            rv.rdy   = $urandom_range(0, 2);
            rv.incr  = 1'b0;
            rv.poke  = ($urandom_range(0, 3) == 0) && (L >= 3) && (rv.nfifo >= 3);
            rv.exp_pay  = (rv.nfifo < L) ? rv.nfifo : L;
            rv.exp_done = (rv.nfifo >= L);
            rv.exp_und  = (rv.nfifo < L);
            run_packet(rv, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
